uart_tx_fifo_cfg: RTL and testbench

Parametrised UART transmitter, next generation of the team's fixed-format TX. Frame format is runtime-configurable: 5..DATA_BITS_MAX data bits, none/even/odd parity, 1 or 2 stop bits. Adds a valid/ready input FIFO for back-to-back frames and break generation. Sits between the host-side byte stream and the tx pin, driven by the shared oversampling baud tick generator.

---
 rtl/uart_tx_fifo_cfg.sv | 117 +++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: runtime-configurable UART transmitter with valid/ready input FIFO and break generation.
module uart_tx_fifo_cfg #(
  parameter int DATA_BITS_MAX = 8,
  parameter int OS_TICKS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic [DATA_BITS_MAX-1:0] s_data,
  input  logic s_valid,
  output logic s_ready,
  input  logic [$clog2(DATA_BITS_MAX+1)-1:0] cfg_data_bits,
  input  logic [1:0] cfg_parity,
  input  logic cfg_stop2,
  input  logic send_break,
  output logic tx,
  output logic busy,
  output logic tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int DW = $clog2(DATA_BITS_MAX+1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = OS_TICKS > 1 ? $clog2(OS_TICKS) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_n;
  logic [DATA_BITS_MAX-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_BITS_MAX-1:0] shreg, mask;
  logic [DW-1:0] nbits, nbits_cfg, bit_cnt;
  logic [CW-1:0] tick_cnt;
  logic par_en, par_bit, stop2, push, pop, bit_end, tx_n, done_n;
  assign s_ready = fifo_level < LW'(FIFO_DEPTH);
  assign busy = state != IDLE;
  assign push = s_valid && s_ready;
  assign bit_end = tick && tick_cnt == CW'(OS_TICKS - 1);
  assign nbits_cfg = (cfg_data_bits < DW'(5) || cfg_data_bits > DW'(DATA_BITS_MAX)) ? DW'(DATA_BITS_MAX) : cfg_data_bits;
  assign mask = {DATA_BITS_MAX{1'b1}} >> (DATA_BITS_MAX - int'(nbits_cfg));
  always_comb begin
    state_n = state;
    tx_n = tx;
    done_n = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE:
        if (send_break) begin
          state_n = BREAK;
          tx_n = 1'b0;
        end else if (fifo_level != '0) begin
          state_n = START;
          tx_n = 1'b0;
          pop = 1'b1;
        end
      START:
        if (bit_end) begin
          state_n = DATA;
          tx_n = shreg[0];
        end
      DATA:
        if (bit_end) begin
          state_n = bit_cnt == nbits - 1'b1 ? (par_en ? PARITY : STOP) : DATA;
          tx_n = bit_cnt == nbits - 1'b1 ? (par_en ? par_bit : 1'b1) : shreg[1];
        end
      PARITY:
        if (bit_end) begin
          state_n = STOP;
          tx_n = 1'b1;
        end
      STOP:
        if (bit_end && bit_cnt == DW'(stop2)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      BREAK: begin
        tx_n = !send_break;
        state_n = !send_break && bit_end ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data;
  // tick counter is held clear while the line is held low so the release mark lasts a full bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      tx_done <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      nbits <= '0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
      stop2 <= 1'b0;
    end else begin
      state <= state_n;
      tx <= tx_n;
      tx_done <= done_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      tick_cnt <= (state == IDLE || (state == BREAK && send_break) || bit_end) ? '0 : tick ? tick_cnt + 1'b1 : tick_cnt;
      bit_cnt <= state_n != state ? '0 : bit_end ? bit_cnt + 1'b1 : bit_cnt;
      if (pop) begin
        shreg <= mem[rd_ptr] & mask;
        nbits <= nbits_cfg;
        par_en <= cfg_parity == 2'b01 || cfg_parity == 2'b10;
        par_bit <= ^(mem[rd_ptr] & mask) ^ cfg_parity[1];
        stop2 <= cfg_stop2;
      end else if (state == DATA && bit_end) shreg <= shreg >> 1;
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: directed bench for uart_tx_fifo_cfg (OS_TICKS=16, tick every 4 clk, 64 clk per bit).
module tb_uart_tx_fifo_cfg;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, s_valid = 1'b0, cfg_stop2 = 1'b0, send_break = 1'b0;
  logic [7:0] s_data = '0;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic tx, busy, tx_done, s_ready;
  logic [2:0] fifo_level;
  int n_cmp = 0, n_bad = 0, tick_total = 0, tdiv = 0, done_cnt = 0, done_tick = 0;
  int st = 0, d0 = 0, waited = 0, t0 = 0, t1 = 0, dd = 0, highs = 0, guard = 0;
  uart_tx_fifo_cfg dut (
    .clk(clk), .reset(reset), .tick(tick), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .send_break(send_break), .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    tdiv = (tdiv + 1) % 4;
    tick = tdiv == 0;
    if (tick) tick_total++;
  end
  always @(posedge clk) begin
    #1;
    if (tx_done) begin
      done_cnt++;
      done_tick = tick_total;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    s_data = d;
    s_valid = 1'b1;
    cyc(1);
    s_valid = 1'b0;
  endtask
  function automatic logic [15:0] f81(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction
  task automatic fstart(input string tag);
    waited = 0;
    while (tx !== 1'b0 && waited < 3000) begin
      cyc(1);
      waited++;
    end
    chk({tag, "_start"}, tx, 0);
    st = tick_total;
    d0 = done_cnt;
  endtask
  task automatic fbody(input string tag, input logic [15:0] bits, input int n, input int ticks, input int skip);
    cyc(32 - skip);
    for (int i = 0; i < n; i++) begin
      if (i > 0) cyc(64);
      chk($sformatf("%s_bit%0d", tag, i), tx, bits[i]);
    end
    for (int i = 0; i < 200 && busy !== 1'b0; i++) cyc(1);
    #1;
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_ticks"}, done_tick - st, ticks);
  endtask
  initial begin
    cyc(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_level", fifo_level, 0);
    reset = 1'b0;
    cyc(8);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    // 8N1 0x55
    push(8'h55);
    fstart("n81");
    fbody("n81", 16'h02AA, 10, 160, 0);
    // 7E2 0x41, config changed mid-frame must not matter
    cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    push(8'h41);
    fstart("e72");
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    fbody("e72", 16'h0682, 11, 176, 0);
    // 8O1 0x00
    cfg_data_bits = 4'd8; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
    push(8'h00);
    fstart("o81");
    fbody("o81", 16'h0600, 11, 176, 0);
    // 5E1 0xFF: upper bits ignored in data and parity
    cfg_data_bits = 4'd5; cfg_parity = 2'b01;
    push(8'hFF);
    fstart("e51");
    fbody("e51", 16'h00FE, 8, 128, 0);
    // FIFO fill with s_valid held high
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5;
    cyc(1);
    chk("q_lvl1", fifo_level, 1);
    s_data = 8'h3C;
    cyc(1);
    fstart("q0");
    chk("q_lvl_swap", fifo_level, 1);
    s_data = 8'h01; cyc(1);
    s_data = 8'h80; cyc(1);
    s_data = 8'hF0; cyc(1);
    chk("q_full_ready", s_ready, 0);
    chk("q_full_level", fifo_level, 4);
    s_data = 8'h5A;
    fbody("q0", f81(8'hA5), 10, 160, 3);
    fstart("q1");
    chk("q1_gap", waited <= 1, 1);
    cyc(1);
    s_valid = 1'b0;
    chk("q_sixth", fifo_level, 4);
    fbody("q1", f81(8'h3C), 10, 160, 1);
    fstart("q2");
    chk("q2_gap", waited <= 1, 1);
    fbody("q2", f81(8'h01), 10, 160, 0);
    fstart("q3");
    chk("q3_gap", waited <= 1, 1);
    fbody("q3", f81(8'h80), 10, 160, 0);
    fstart("q4");
    chk("q4_gap", waited <= 1, 1);
    fbody("q4", f81(8'hF0), 10, 160, 0);
    fstart("q5");
    chk("q5_gap", waited <= 1, 1);
    fbody("q5", f81(8'h5A), 10, 160, 0);
    chk("q_empty", fifo_level, 0);
    // break requested mid-frame, with a word queued behind it
    push(8'h96);
    fstart("bf");
    push(8'hC3);
    send_break = 1'b1;
    fbody("bf", f81(8'h96), 10, 160, 1);
    cyc(1);
    chk("brk_tx", tx, 0);
    chk("brk_busy", busy, 1);
    chk("brk_nopop", fifo_level, 1);
    t0 = tick_total; highs = 0; guard = 0;
    while (tick_total - t0 < 300 && guard < 2000) begin
      cyc(1);
      guard++;
      if (tx !== 1'b0) highs++;
    end
    chk("brk_held_low", highs, 0);
    chk("brk_hold_level", fifo_level, 1);
    send_break = 1'b0;
    t1 = tick_total; dd = done_cnt;
    cyc(1);
    chk("brk_rel_tx", tx, 1);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) cyc(1);
    chk("brk_rel_busy", busy, 0);
    chk("brk_rel_ticks", tick_total - t1, 16);
    #1;
    chk("brk_no_done", done_cnt - dd, 0);
    fstart("bq");
    chk("bq_gap", waited <= 1, 1);
    fbody("bq", f81(8'hC3), 10, 160, 0);
    // reset during DATA with two words queued
    push(8'h00);
    fstart("rf");
    push(8'h11);
    push(8'h22);
    chk("rf_level", fifo_level, 2);
    cyc(200);
    chk("rf_pre_tx", tx, 0);
    dd = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    chk("rf_rst_tx", tx, 1);
    chk("rf_rst_level", fifo_level, 0);
    chk("rf_rst_busy", busy, 0);
    chk("rf_rst_ready", s_ready, 1);
    cyc(2);
    reset = 1'b0;
    cyc(100);
    chk("rf_no_done", done_cnt - dd, 0);
    chk("rf_quiet_tx", tx, 1);
    chk("rf_quiet_level", fifo_level, 0);
    push(8'hE7);
    fstart("rn");
    fbody("rn", f81(8'hE7), 10, 160, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
